lsu_mem_ctrl: RTL

Load/store sequencer between the core's memory stage and the word-organised data memory (`dataMem`). It accepts one RV32I load/store request at a time and converts it into one or two word-aligned memory cycles. For writes it generates the byte-lane write mask and lane-shifted data; for reads it merges both halves and sign- or zero-extends them. Misaligned accesses that straddle a word boundary are split into two consecutive memory cycles instead of trapping.

---
 rtl/lsu_mem_ctrl.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/lsu_mem_ctrl.sv
// Load/store sequencer between the memory stage and the word-organised data memory.
// Each request becomes one or two word-aligned memory cycles; accesses that cross a
// word boundary are split rather than trapped. All outputs are registered.
module lsu_mem_ctrl #(
   parameter int unsigned ADDR_WIDTH = 10,
   parameter int unsigned DATA_WIDTH = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  req_valid_i,
   output logic                  req_ready_o,
   input  logic                  req_we_i,
   input  logic [2:0]            req_funct3_i,
   input  logic [ADDR_WIDTH-1:0] req_addr_i,
   input  logic [DATA_WIDTH-1:0] req_wdata_i,
   output logic                  rsp_valid_o,
   output logic [DATA_WIDTH-1:0] rsp_rdata_o,
   output logic                  rsp_err_o,
   output logic                  mem_we_o,
   output logic [ADDR_WIDTH-1:0] mem_addr_o,
   output logic [DATA_WIDTH-1:0] mem_wdata_o,
   output logic [3:0]            mem_wmask_o,
   input  logic [DATA_WIDTH-1:0] mem_rdata_i
);

   localparam logic [ADDR_WIDTH-1:0] AddrMax = '1;

   typedef enum logic [1:0] {StIdle, StAcc0, StAcc1, StResp} state_t;

   state_t                state_q;
   logic                  we_q;
   logic [2:0]            f3_q;
   logic [1:0]            off_q;
   logic                  split_q;
   logic [7:0]            mask_q;
   logic [63:0]           data_q;
   logic [31:0]           rd0_q;

   logic                  ready_q;
   logic                  rsp_valid_q;
   logic [31:0]           rsp_rdata_q;
   logic                  rsp_err_q;
   logic                  mem_we_q;
   logic [ADDR_WIDTH-1:0] mem_addr_q;
   logic [31:0]           mem_wdata_q;
   logic [3:0]            mem_wmask_q;

   logic [2:0]            req_nm1;
   logic [3:0]            req_bytes;
   logic [31:0]           req_lanes;
   logic                  req_wrap;
   logic                  req_err;
   logic [7:0]            req_mask8;
   logic [63:0]           req_data64;

   logic [63:0]           rd_cat;
   logic [31:0]           rd_sh;
   logic [31:0]           load_data;

   // Decode size, legality and lane placement of the incoming request
   always_comb begin
      req_nm1   = 3'd0;
      req_bytes = 4'b0001;
      case (req_funct3_i[1:0])
         2'b00: begin
            req_nm1   = 3'd0;
            req_bytes = 4'b0001;
         end
         2'b01: begin
            req_nm1   = 3'd1;
            req_bytes = 4'b0011;
         end
         default: begin
            req_nm1   = 3'd3;
            req_bytes = 4'b1111;
         end
      endcase
      req_lanes  = {{8{req_bytes[3]}}, {8{req_bytes[2]}}, {8{req_bytes[1]}}, {8{req_bytes[0]}}};
      // Last byte of the access must not run past the top of the address space
      req_wrap   = req_addr_i > (AddrMax - ADDR_WIDTH'(req_nm1));
      req_err    = (req_funct3_i == 3'b011) || (req_funct3_i[2:1] == 2'b11) ||
                   (req_we_i && req_funct3_i[2]) || req_wrap;
      req_mask8  = {4'b0000, req_bytes} << req_addr_i[1:0];
      // Bytes beyond the access size are cleared so unused lanes go out as zero
      req_data64 = {32'h0, req_wdata_i & req_lanes} << {req_addr_i[1:0], 3'b000};
   end

   // Merge the read words, realign to the byte offset and extend to 32 bits
   always_comb begin
      rd_cat = (state_q == StAcc1) ? {mem_rdata_i, rd0_q} : {32'h0, mem_rdata_i};
      rd_sh  = rd_cat[{off_q, 3'b000} +: 32];
      case (f3_q)
         3'b000:  load_data = {{24{rd_sh[7]}}, rd_sh[7:0]};
         3'b001:  load_data = {{16{rd_sh[15]}}, rd_sh[15:0]};
         3'b100:  load_data = {24'h0, rd_sh[7:0]};
         3'b101:  load_data = {16'h0, rd_sh[15:0]};
         default: load_data = rd_sh;
      endcase
   end

   // Sequencer FSM; every output is set on the edge that enters the state using it
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= StIdle;
         we_q        <= 1'b0;
         f3_q        <= 3'b000;
         off_q       <= 2'b00;
         split_q     <= 1'b0;
         mask_q      <= 8'h00;
         data_q      <= 64'h0;
         rd0_q       <= 32'h0;
         ready_q     <= 1'b1;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= 32'h0;
         rsp_err_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= 32'h0;
         mem_wmask_q <= 4'h0;
      end else begin
         case (state_q)
            StIdle: begin
               if (req_valid_i) begin
                  we_q    <= req_we_i;
                  f3_q    <= req_funct3_i;
                  off_q   <= req_addr_i[1:0];
                  split_q <= |req_mask8[7:4];
                  mask_q  <= req_mask8;
                  data_q  <= req_data64;
                  ready_q <= 1'b0;
                  if (req_err) begin
                     state_q     <= StResp;
                     rsp_valid_q <= 1'b1;
                     rsp_err_q   <= 1'b1;
                     rsp_rdata_q <= 32'h0;
                  end else begin
                     state_q     <= StAcc0;
                     mem_we_q    <= req_we_i;
                     mem_addr_q  <= {req_addr_i[ADDR_WIDTH-1:2], 2'b00};
                     mem_wmask_q <= req_we_i ? req_mask8[3:0] : 4'h0;
                     mem_wdata_q <= req_we_i ? req_data64[31:0] : 32'h0;
                  end
               end
            end
            StAcc0: begin
               rd0_q <= mem_rdata_i;
               if (split_q) begin
                  state_q     <= StAcc1;
                  mem_addr_q  <= mem_addr_q + ADDR_WIDTH'(4);
                  mem_wmask_q <= we_q ? mask_q[7:4] : 4'h0;
                  mem_wdata_q <= we_q ? data_q[63:32] : 32'h0;
               end else begin
                  state_q     <= StResp;
                  mem_we_q    <= 1'b0;
                  mem_addr_q  <= '0;
                  mem_wmask_q <= 4'h0;
                  mem_wdata_q <= 32'h0;
                  rsp_valid_q <= 1'b1;
                  rsp_rdata_q <= we_q ? 32'h0 : load_data;
               end
            end
            StAcc1: begin
               state_q     <= StResp;
               mem_we_q    <= 1'b0;
               mem_addr_q  <= '0;
               mem_wmask_q <= 4'h0;
               mem_wdata_q <= 32'h0;
               rsp_valid_q <= 1'b1;
               rsp_rdata_q <= we_q ? 32'h0 : load_data;
            end
            default: begin
               state_q     <= StIdle;
               ready_q     <= 1'b1;
               rsp_valid_q <= 1'b0;
               rsp_err_q   <= 1'b0;
               rsp_rdata_q <= 32'h0;
            end
         endcase
      end
   end

   assign req_ready_o = ready_q;
   assign rsp_valid_o = rsp_valid_q;
   assign rsp_rdata_o = rsp_rdata_q;
   assign rsp_err_o   = rsp_err_q;
   assign mem_we_o    = mem_we_q;
   assign mem_addr_o  = mem_addr_q;
   assign mem_wdata_o = mem_wdata_q;
   assign mem_wmask_o = mem_wmask_q;

endmodule
